// File: rtl/usr_shift_ctrl_if.sv
// Command channel between the host/serial-link FSM and usr_shift_ctrl.
// The host drives the master side; the controller answers on the slave side.
interface usr_shift_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;

  modport master (output cmd_valid, output cmd_op, output cmd_cnt, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_cnt, output cmd_ready);
endinterface

// File: rtl/usr_shift_ctrl.sv
// Command sequencer for a universal shift register: load, shift right/left, rotate right.
// Optional abort input/aborted flag are built when USR_SHIFT_CTRL_ABORT_EN is defined.
module usr_shift_ctrl #(
  parameter int REG_W = 4,
  parameter int CNT_W = $clog2(REG_W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  usr_shift_ctrl_if.slave  cmd,
  input  logic             ser_in,
  input  logic             sr_tap,
  input  logic             sl_tap,
  output logic [1:0]       s,
  output logic             sr,
  output logic             sl,
  output logic             busy,
  output logic             done,
  output logic             ser_out,
  output logic             ser_out_valid
`ifdef USR_SHIFT_CTRL_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             abort_hit;

`ifdef USR_SHIFT_CTRL_ABORT_EN
  logic aborted_q, aborted_d;

  assign abort_hit = abort && (state_q == LOAD || state_q == SHIFT);
  assign aborted_d = abort_hit;
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          op_d  = cmd.cmd_op;
          cnt_d = cmd.cmd_cnt;
          if (cmd.cmd_op == 2'b00)
            state_d = LOAD;
          else if (cmd.cmd_cnt != '0)
            state_d = SHIFT;
          else
            state_d = DONE;
        end
      end
      LOAD:  state_d = DONE;
      SHIFT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1))
          state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit)
      state_d = DONE;
    // Ready is registered so it stays low through reset and the first edge after release.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
`ifdef USR_SHIFT_CTRL_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
`ifdef USR_SHIFT_CTRL_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  // Rotate right feeds the outgoing LSB back into SR, so counts past REG_W just wrap.
  always_comb begin
    s       = 2'b00;
    sr      = 1'b0;
    sl      = 1'b0;
    ser_out = 1'b0;
    case (state_q)
      LOAD:  s = 2'b11;
      SHIFT: begin
        case (op_q)
          2'b01: begin
            s       = 2'b01;
            sr      = ser_in;
            ser_out = sr_tap;
          end
          2'b10: begin
            s       = 2'b10;
            sl      = ser_in;
            ser_out = sl_tap;
          end
          2'b11: begin
            s       = 2'b01;
            sr      = sr_tap;
            ser_out = sr_tap;
          end
          default: s = 2'b00;
        endcase
      end
      default: s = 2'b00;
    endcase
  end

  assign busy          = (state_q == LOAD) || (state_q == SHIFT);
  assign done          = (state_q == DONE);
  assign ser_out_valid = (state_q == SHIFT);
  assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Scoreboard bench for usr_shift_ctrl driving a behavioural 4-bit universal shift register.
// Abort vectors are included when USR_SHIFT_CTRL_ABORT_EN is defined.
module tb_usr_shift_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ser_in;
  logic       sr_tap, sl_tap;
  logic [1:0] s;
  logic       sr, sl, busy, done, ser_out, ser_out_valid;
  logic [3:0] mreg   = 4'b0000;
  logic [3:0] par_in = 4'b0000;
`ifdef USR_SHIFT_CTRL_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  usr_shift_ctrl_if #(.CNT_W(3)) cmd_if ();

  usr_shift_ctrl #(.REG_W(4), .CNT_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd           (cmd_if),
    .ser_in        (ser_in),
    .sr_tap        (sr_tap),
    .sl_tap        (sl_tap),
    .s             (s),
    .sr            (sr),
    .sl            (sl),
    .busy          (busy),
    .done          (done),
    .ser_out       (ser_out),
    .ser_out_valid (ser_out_valid)
`ifdef USR_SHIFT_CTRL_ABORT_EN
    ,
    .abort         (abort),
    .aborted       (aborted)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    bit         val;
    logic [1:0] s;
    int         cyc;
    bit         abrt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   nz_cycles   = 0;
  int   load_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register: right shift enters at the MSB, left shift at the LSB.
  always @(posedge clk) begin
    case (s)
      2'b01:   mreg <= {sr, mreg[3:1]};
      2'b10:   mreg <= {mreg[2:0], sl};
      2'b11:   mreg <= par_in;
      default: mreg <= mreg;
    endcase
  end

  assign sr_tap = mreg[0];
  assign sl_tap = mreg[3];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic noteFail(input string name, input int act, input int req);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT streams a bit or pulses done.
  always @(negedge clk) begin
    if (reset) begin
      if (s != 2'b00) nz_cycles++;
      if (s == 2'b11) load_cycles++;
      if (busy || done)
        checkOutput("ready_low_while_busy", 32'(cmd_if.cmd_ready), 32'(0));
      if (ser_out_valid) begin
        if (sb.size() == 0)
          noteFail("unexpected_ser_out_queue", 0, 1);
        else begin
          mon_e = sb.pop_front();
          checkOutput("ser_item_kind", 32'(mon_e.is_done), 32'(0));
          checkOutput("ser_out", 32'(ser_out), 32'(mon_e.val));
          checkOutput("shift_mode_s", 32'(s), 32'(mon_e.s));
        end
      end
      if (done) begin
        if (sb.size() == 0)
          noteFail("unexpected_done_queue", 0, 1);
        else begin
          mon_e = sb.pop_front();
          checkOutput("done_item_kind", 32'(mon_e.is_done), 32'(1));
          checkOutput("done_cycle", 32'(cyc), 32'(mon_e.cyc));
          checkOutput("done_s_hold", 32'(s), 32'(0));
`ifdef USR_SHIFT_CTRL_ABORT_EN
          checkOutput("aborted_flag", 32'(aborted), 32'(mon_e.abrt));
`endif
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] cnt, input logic sin,
                               input int nbits, input logic [7:0] bits, input logic [1:0] es,
                               input int done_off, input bit eab, input bit keep_valid,
                               output int acc);
    bit   rdy;
    exp_t e;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_cnt   = cnt;
    ser_in           = sin;
    acc = -1;
    for (int b = 0; b < 40; b++) begin
      rdy = cmd_if.cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      noteFail("accept_timeout", 0, 1);
      cmd_if.cmd_valid = 1'b0;
      return;
    end
    for (int i = 0; i < nbits; i++) begin
      e = '{is_done: 1'b0, val: bits[i], s: es, cyc: 0, abrt: 1'b0};
      sb.push_back(e);
    end
    e = '{is_done: 1'b1, val: 1'b0, s: 2'b00, cyc: acc + done_off, abrt: eab};
    sb.push_back(e);
    if (!keep_valid) cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && cmd_if.cmd_ready && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) noteFail("idle_timeout_queue", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, acc_a, acc_b, nz0;
    reset            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_cnt   = 3'd0;
    ser_in           = 1'b0;
`ifdef USR_SHIFT_CTRL_ABORT_EN
    abort            = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_s", 32'(s), 32'(0));
    checkOutput("rst_sr", 32'(sr), 32'(0));
    checkOutput("rst_sl", 32'(sl), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_ser_out", 32'(ser_out), 32'(0));
    checkOutput("rst_ser_out_valid", 32'(ser_out_valid), 32'(0));
    checkOutput("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'(0));
    reset = 1'b1;
    #1 checkOutput("ready_before_first_edge", 32'(cmd_if.cmd_ready), 32'(0));
    @(posedge clk);
    #1 checkOutput("ready_after_release", 32'(cmd_if.cmd_ready), 32'(1));

    // Reset in the middle of a shift-right, cnt=3, after one shift
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'b01;
    cmd_if.cmd_cnt   = 3'd3;
    ser_in           = 1'b0;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    sb.push_back('{is_done: 1'b0, val: 1'b0, s: 2'b01, cyc: 0, abrt: 1'b0});
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midcmd_rst_s", 32'(s), 32'(0));
    checkOutput("midcmd_rst_busy", 32'(busy), 32'(0));
    checkOutput("midcmd_rst_done", 32'(done), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    checkOutput("midcmd_first_shift_seen", 32'(sb.size()), 32'(0));
    sb.delete();
    #1 checkOutput("midcmd_ready_pre_edge", 32'(cmd_if.cmd_ready), 32'(0));
    @(posedge clk);
    #1 checkOutput("midcmd_ready_post_edge", 32'(cmd_if.cmd_ready), 32'(1));

    // Load 1011
    par_in      = 4'b1011;
    load_cycles = 0;
    applyStimulus(2'b00, 3'd5, 1'b0, 0, 8'h00, 2'b00, 1, 1'b0, 1'b0, acc);
    waitIdle();
    checkOutput("load_s11_cycles", 32'(load_cycles), 32'(1));
    checkOutput("load_reg_value", 32'(mreg), 32'(4'b1011));

    // Shift right x4, ser_in=0: stream 1,1,0,1
    applyStimulus(2'b01, 3'd4, 1'b0, 4, 8'b0000_1011, 2'b01, 4, 1'b0, 1'b0, acc);
    waitIdle();
    checkOutput("shr_final_reg", 32'(mreg), 32'(4'b0000));

    // Load 1001 then rotate right x5: stream 1,0,0,1,1
    par_in = 4'b1001;
    applyStimulus(2'b00, 3'd0, 1'b0, 0, 8'h00, 2'b00, 1, 1'b0, 1'b0, acc);
    waitIdle();
    checkOutput("load2_reg_value", 32'(mreg), 32'(4'b1001));
    applyStimulus(2'b11, 3'd5, 1'b0, 5, 8'b0001_1001, 2'b01, 5, 1'b0, 1'b0, acc);
    waitIdle();
    checkOutput("rot_final_reg", 32'(mreg), 32'(4'b1100));

    // Shift left with cnt=0: no mode activity, done right after accept
    nz0 = nz_cycles;
    applyStimulus(2'b10, 3'd0, 1'b1, 0, 8'h00, 2'b00, 0, 1'b0, 1'b0, acc);
    waitIdle();
    checkOutput("shl_cnt0_no_shift", 32'(nz_cycles), 32'(nz0));
    checkOutput("shl_cnt0_reg_kept", 32'(mreg), 32'(4'b1100));

    // Shift left x2, ser_in=1 from 1100: stream 1,1 -> 0011
    applyStimulus(2'b10, 3'd2, 1'b1, 2, 8'b0000_0011, 2'b10, 2, 1'b0, 1'b0, acc);
    waitIdle();
    checkOutput("shl_final_reg", 32'(mreg), 32'(4'b0011));

    // Back-to-back with valid held: shr x2 (sin=1) then rotate x1
    applyStimulus(2'b01, 3'd2, 1'b1, 2, 8'b0000_0011, 2'b01, 2, 1'b0, 1'b1, acc_a);
    applyStimulus(2'b11, 3'd1, 1'b1, 1, 8'b0000_0000, 2'b01, 1, 1'b0, 1'b0, acc_b);
    checkOutput("b2b_second_accept_cycle", 32'(acc_b), 32'(acc_a + 4));
    waitIdle();
    checkOutput("b2b_final_reg", 32'(mreg), 32'(4'b0110));

`ifdef USR_SHIFT_CTRL_ABORT_EN
    // Shift right cnt=7 from 0110, abort during third shift: stream 0,1,1
    applyStimulus(2'b01, 3'd7, 1'b0, 3, 8'b0000_0110, 2'b01, 3, 1'b1, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    waitIdle();
    checkOutput("abort_final_reg", 32'(mreg), 32'(4'b0000));
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
